// File: rtl/pipelined_inst_decoder.sv
// pipelined_inst_decoder: registered decode stage with valid/ready handshake,
// load-use bubble, branch flush, halt/resume FSM and saturating perf counters.
module pipelined_inst_decoder #(
  parameter int RA_W = 3,
  parameter int CNT_W = 16,
  localparam int INST_W = 4 + 3*RA_W + 3,
  localparam int IMM_W = RA_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  input  logic              flush,
  input  logic              resume,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RA_W-1:0]   dr,
  output logic [RA_W-1:0]   sa,
  output logic [RA_W-1:0]   sb,
  output logic [IMM_W-1:0]  imm,
  output logic [IMM_W-1:0]  off,
  output logic              mb,
  output logic              md,
  output logic              ld,
  output logic              mw,
  output logic              hlt,
  output logic [2:0]        fs,
  output logic [2:0]        bs,
  output logic              halted,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_d;
  logic [3:0] op;
  logic [RA_W-1:0] rs, rt, rd;
  logic [2:0] funct;
  logic [IMM_W-1:0] imm_f;
  logic [RA_W-1:0] d_dr, d_sa, d_sb;
  logic [IMM_W-1:0] d_imm, d_off;
  logic d_mb, d_md, d_ld, d_mw, d_hlt, rd_a, rd_b;
  logic [2:0] d_fs, d_bs;
  logic hazard, xfer;
  assign op = in_inst[INST_W-1 -: 4];
  assign rs = in_inst[INST_W-5 -: RA_W];
  assign rt = in_inst[INST_W-5-RA_W -: RA_W];
  assign rd = in_inst[3+RA_W-1 -: RA_W];
  assign funct = in_inst[2:0];
  assign imm_f = in_inst[IMM_W-1:0];
  always_comb begin
    d_dr = '0;
    d_sa = '0;
    d_sb = '0;
    d_imm = '0;
    d_off = '0;
    d_mb = 1'b0;
    d_md = 1'b0;
    d_ld = 1'b0;
    d_mw = 1'b0;
    d_hlt = 1'b0;
    d_fs = 3'b000;
    d_bs = 3'b100;
    rd_a = 1'b0;
    rd_b = 1'b0;
    case (op)
      4'b0010: begin
        d_dr = rt;
        d_sa = rs;
        d_imm = imm_f;
        d_mb = 1'b1;
        d_md = 1'b1;
        d_ld = 1'b1;
        rd_a = 1'b1;
      end
      4'b0100: begin
        d_sa = rs;
        d_sb = rt;
        d_imm = imm_f;
        d_mb = 1'b1;
        d_mw = 1'b1;
        rd_a = 1'b1;
        rd_b = 1'b1;
      end
      4'b0101, 4'b0110: begin
        d_dr = rt;
        d_sa = rs;
        d_imm = imm_f;
        d_mb = 1'b1;
        d_ld = 1'b1;
        d_fs = op[1] ? 3'b101 : 3'b000;
        rd_a = 1'b1;
      end
      4'b1111: begin
        d_dr = rd;
        d_sa = rs;
        d_ld = 1'b1;
        d_fs = funct;
        rd_a = 1'b1;
        rd_b = funct inside {3'b000, 3'b001, 3'b101, 3'b110};
        d_sb = rd_b ? rt : '0;
      end
      4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
        d_sa = rs;
        d_fs = 3'b001;
        d_off = imm_f;
        d_bs = {1'b0, op[1:0]};
        d_mb = op[1];
        rd_a = 1'b1;
        rd_b = !op[1];
        d_sb = rd_b ? rt : '0;
      end
      default: begin
        d_hlt = funct == 3'b001;
        d_fs = funct;
      end
    endcase
  end
  // Only a held load can create a load-use hazard; r0 never does.
  assign hazard = out_valid & md & ld & (dr != '0) & ((rd_a & d_sa == dr) | (rd_b & d_sb == dr));
  assign in_ready = rst_n & (state == RUN) & !flush & !hazard & (!out_valid | out_ready);
  assign xfer = in_valid & in_ready;
  assign halted = state == HALT;
  always_comb begin
    state_d = state;
    if (state == HALT && (flush || resume)) state_d = RUN;
    else if (state == RUN && xfer && d_hlt) state_d = HALT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      dr <= '0;
      sa <= '0;
      sb <= '0;
      imm <= '0;
      off <= '0;
      mb <= 1'b0;
      md <= 1'b0;
      ld <= 1'b0;
      mw <= 1'b0;
      hlt <= 1'b0;
      fs <= 3'b000;
      bs <= 3'b100;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      dr <= d_dr;
      sa <= d_sa;
      sb <= d_sb;
      imm <= d_imm;
      off <= d_off;
      mb <= d_mb;
      md <= d_md;
      ld <= d_ld;
      mw <= d_mw;
      hlt <= d_hlt;
      fs <= d_fs;
      bs <= d_bs;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      issue_cnt <= (out_valid & out_ready & ~&issue_cnt) ? issue_cnt + 1'b1 : issue_cnt;
      stall_cnt <= (in_valid & !in_ready & state == RUN & ~&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
    end
endmodule

// File: tb/tb_pipelined_inst_decoder.sv
// tb_pipelined_inst_decoder: directed stimulus checked by literal expectations
// and by a table-driven cycle model compared every cycle.
module tb_pipelined_inst_decoder;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, resume = 1'b0, out_ready = 1'b1;
  logic [15:0] in_inst = '0;
  logic in_ready, out_valid, mb, md, ld, mw, hlt, halted;
  logic [2:0] dr, sa, sb, fs, bs;
  logic [5:0] imm, off;
  logic [15:0] issue_cnt, stall_cnt;
  int passed = 0, total = 0;
  typedef struct packed {
    logic [2:0] dr, sa, sb;
    logic [5:0] imm, off;
    logic mb, md, ld, mw, hlt;
    logic [2:0] fs, bs;
  } bun_t;
  typedef struct packed {
    bun_t b;
    logic [7:0] reads;
  } dec_t;
  pipelined_inst_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .flush(flush), .resume(resume), .out_valid(out_valid), .out_ready(out_ready),
    .dr(dr), .sa(sa), .sb(sb), .imm(imm), .off(off), .mb(mb), .md(md), .ld(ld), .mw(mw),
    .hlt(hlt), .fs(fs), .bs(bs), .halted(halted), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  bun_t db;
  assign db = {dr, sa, sb, imm, off, mb, md, ld, mw, hlt, fs, bs};
  function automatic dec_t dec(input logic [15:0] i);
    dec_t d;
    logic [2:0] rs, rt, rd, fn;
    rs = i[11:9];
    rt = i[8:6];
    rd = i[5:3];
    fn = i[2:0];
    d = '0;
    d.b.bs = 3'b100;
    case (i[15:12])
      4'h2: begin d.b.dr = rt; d.b.sa = rs; d.b.imm = i[5:0]; d.b.mb = 1; d.b.md = 1; d.b.ld = 1; d.reads[rs] = 1; end
      4'h4: begin d.b.sa = rs; d.b.sb = rt; d.b.imm = i[5:0]; d.b.mb = 1; d.b.mw = 1; d.reads[rs] = 1; d.reads[rt] = 1; end
      4'h5: begin d.b.dr = rt; d.b.sa = rs; d.b.imm = i[5:0]; d.b.mb = 1; d.b.ld = 1; d.reads[rs] = 1; end
      4'h6: begin d.b.dr = rt; d.b.sa = rs; d.b.imm = i[5:0]; d.b.mb = 1; d.b.ld = 1; d.b.fs = 3'd5; d.reads[rs] = 1; end
      4'hF: begin
        d.b.dr = rd; d.b.sa = rs; d.b.ld = 1; d.b.fs = fn; d.reads[rs] = 1;
        if (fn == 0 || fn == 1 || fn == 5 || fn == 6) begin d.b.sb = rt; d.reads[rt] = 1; end
      end
      4'h8: begin d.b.sa = rs; d.b.sb = rt; d.b.fs = 1; d.b.off = i[5:0]; d.b.bs = 0; d.reads[rs] = 1; d.reads[rt] = 1; end
      4'h9: begin d.b.sa = rs; d.b.sb = rt; d.b.fs = 1; d.b.off = i[5:0]; d.b.bs = 1; d.reads[rs] = 1; d.reads[rt] = 1; end
      4'hA: begin d.b.sa = rs; d.b.mb = 1; d.b.fs = 1; d.b.off = i[5:0]; d.b.bs = 2; d.reads[rs] = 1; end
      4'hB: begin d.b.sa = rs; d.b.mb = 1; d.b.fs = 1; d.b.off = i[5:0]; d.b.bs = 3; d.reads[rs] = 1; end
      default: begin d.b.hlt = fn == 1; d.b.fs = fn; end
    endcase
    return d;
  endfunction
  logic m_valid, m_halt, m_rdy, m_haz;
  bun_t m_b;
  logic [15:0] m_issue, m_stall;
  dec_t m_dec;
  assign m_dec = dec(in_inst);
  assign m_haz = m_valid && m_b.md && m_b.ld && m_b.dr != 0 && m_dec.reads[m_b.dr];
  assign m_rdy = rst_n && !m_halt && !flush && !m_haz && (!m_valid || out_ready);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 0;
      m_halt <= 0;
      m_b <= 32'd4;
      m_issue <= 0;
      m_stall <= 0;
    end else begin
      if (flush) m_valid <= 0;
      else if (in_valid && m_rdy) begin m_valid <= 1; m_b <= m_dec.b; end
      else if (out_ready) m_valid <= 0;
      if (m_halt && (flush || resume)) m_halt <= 0;
      else if (!m_halt && in_valid && m_rdy && m_dec.b.hlt) m_halt <= 1;
      if (m_valid && out_ready && m_issue != 16'hFFFF) m_issue <= m_issue + 1;
      if (in_valid && !m_rdy && !m_halt && m_stall != 16'hFFFF) m_stall <= m_stall + 1;
    end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
  endtask
  always @(negedge clk) begin
    chk("m_in_ready", in_ready, m_rdy);
    chk("m_out_valid", out_valid, m_valid);
    chk("m_halted", halted, m_halt);
    chk("m_issue_cnt", issue_cnt, m_issue);
    chk("m_stall_cnt", stall_cnt, m_stall);
    if (m_valid) chk("m_bundle", db, m_b);
  end
  task automatic set(input logic v, input logic [15:0] i, input logic o, input logic f = 0, input logic r = 0);
    in_valid = v;
    in_inst = i;
    out_ready = o;
    flush = f;
    resume = r;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic [15:0] tbl [12] = '{16'h4283, 16'h5283, 16'h6283, 16'h9285, 16'hA285, 16'hB285,
                            16'hF28D, 16'h3123, 16'h2283, 16'h4483, 16'h2003, 16'hF000};
  initial begin
    set(1, 16'hF28A, 1);
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bundle", db, 32'd4);
    chk("rst_counters", {issue_cnt, stall_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("rt_in_ready", in_ready, 1);
    tick;
    chk("rt_regs", {dr, sa, sb, fs, ld}, {3'd1, 3'd1, 3'd0, 3'd2, 1'b1});
    set(0, 16'hF28A, 1);
    tick;
    chk("rt_issue", issue_cnt, 1);
    set(1, 16'h2283, 1);
    tick;
    set(1, 16'hF4A8, 1);
    #1;
    chk("lu_hazard_ready", in_ready, 0);
    tick;
    chk("lu_bubble", {out_valid, in_ready}, 2'b01);
    chk("lu_stall", stall_cnt, 1);
    tick;
    chk("lu_second", {out_valid, dr, sa, sb}, {1'b1, 3'd5, 3'd2, 3'd2});
    set(1, 16'h8285, 1);
    tick;
    chk("bp_issue_before", issue_cnt, 3);
    set(0, 16'h8285, 0);
    repeat (3) begin
      #1;
      chk("bp_hold", {in_ready, out_valid, bs, off}, {1'b0, 1'b1, 3'd0, 6'd5});
      tick;
    end
    set(0, 16'h8285, 1);
    tick;
    chk("bp_issue_after", {out_valid, issue_cnt}, {1'b0, 16'd4});
    set(1, 16'h0001, 1);
    tick;
    chk("halt_set", {halted, hlt}, 2'b11);
    set(1, 16'hF28A, 1);
    #1;
    chk("halt_ready", in_ready, 0);
    tick;
    set(0, 16'hF28A, 1, 0, 1);
    tick;
    chk("resume", halted, 0);
    set(1, 16'hF28A, 1);
    #1;
    chk("resume_ready", in_ready, 1);
    tick;
    set(1, 16'h0001, 1);
    tick;
    set(0, 16'h0001, 0);
    tick;
    set(1, 16'hF28A, 0, 1, 0);
    #1;
    chk("flush_ready", in_ready, 0);
    tick;
    chk("flush_result", {out_valid, halted, issue_cnt}, {1'b0, 1'b0, 16'd6});
    set(1, 16'h0001, 1);
    tick;
    set(0, 16'h0001, 0, 1, 1);
    tick;
    chk("flush_resume", halted, 0);
    for (int k = 0; k < 12; k++) begin
      set(1, tbl[k], k % 3 != 2, k == 7);
      tick;
    end
    set(0, 16'h0000, 1);
    tick;
    set(1, 16'h2283, 0);
    tick;
    tick;
    rst_n = 0;
    #1;
    chk("midrst", {out_valid, halted, issue_cnt, stall_cnt, db}, {2'b00, 32'd0, 32'd4});
    tick;
    rst_n = 1;
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipelined_inst_decoder.md
Name: pipelined_inst_decoder

Overview:
- Registered, parametrised instruction-decode stage for the CPU.
- Decodes one instruction per cycle into the datapath control bundle. The bundle is DR/SA/SB/IMM/MB/FS/MD/LD/MW/HLT/BS/OFF.
- Output is held in a pipeline register with a valid/ready handshake on both sides.
- Adds a load-use hazard bubble, a branch flush, a halt/resume state machine and saturating performance counters.

Parameters:
- RA_W, 3, register-address width; FUNCT_W=3, OP_W=4 are fixed; INST_W = 4+3*RA_W+3; IMM_W = RA_W+3.
- CNT_W, 16, width of issue and stall counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_inst  in  INST_W  fields, MSB first: OP[4], RS[RA_W], RT[RA_W], RD[RA_W], FUNCT[3]; IMM = low IMM_W bits.
- in_ready  out  1  stage accepts this cycle.
- flush  in  1  branch taken; squash held instruction.
- resume  in  1  leave HALT.
- out_valid  out  1  bundle valid.
- out_ready  in  1  downstream accepts.
- dr, sa, sb  out  RA_W each  register selects.
- imm, off  out  IMM_W each  immediate and branch offset.
- mb, md, ld, mw, hlt  out  1 each  control bits.
- fs  out  3  ALU function.
- bs  out  3  branch select; 3'b100 means no branch.
- halted  out  1  state==HALT.
- issue_cnt, stall_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (async): out_valid=0, bundle all zero except bs=3'b100, state=RUN, counters=0, in_ready=0 while rst_n low.
- Decode table: no X outputs; every unused field is driven 0, bs=3'b100, off=0.
  - OP 0000: NOP; hlt=1 iff FUNCT=001; fs=FUNCT.
  - OP 0010: load. dr=RT, sa=RS, imm, mb=1, md=1, ld=1.
  - OP 0100: store. sa=RS, sb=RT, imm, mb=1, mw=1.
  - OP 0101: addi. dr=RT, sa=RS, imm, mb=1, ld=1, fs=000.
  - OP 0110: same as 0101 but fs=101.
  - OP 1111: R-type. dr=RD, sa=RS, ld=1, fs=FUNCT; sb=RT when FUNCT is 000/001/101/110, else 0.
  - OP 1000/1001/1010/1011: beq/bne/bgez/bltz. sa=RS, fs=001, off=IMM, bs=000/001/010/011. sb=RT for beq/bne only; mb=1 for bgez/bltz.
  - Any other OP decodes as NOP.
- Reads: incoming reads sa always for non-NOP; reads sb for store, beq, bne and R-type with sb=RT.
- Hazard: out_valid & md & ld & dr!=0, and the incoming instruction reads register dr.
- in_ready = state==RUN & !flush & !hazard & (!out_valid | out_ready).
- Transfer (in_valid & in_ready): bundle registered next edge, out_valid=1; latency 1 cycle.
- Draining without new transfer (out_valid & out_ready): out_valid=0. A hazard therefore yields exactly one bubble cycle.
- Stalled output (out_valid & !out_ready): bundle held stable.
- flush: out_valid=0 next edge; no input accepted that cycle; flush beats accept and hazard.
- State RUN→HALT: when a transfer carries hlt=1; in_ready=0 in HALT.
- State HALT→RUN: on resume, or on flush because the halting instruction was squashed. Simultaneous flush and resume → RUN.
- resume in RUN: ignored.
- issue_cnt: +1 on each out_valid & out_ready.
- stall_cnt: +1 on each cycle with in_valid & !in_ready & state==RUN.
- Counters saturate at all-ones and do not wrap.
- Reset mid-operation: immediate return to reset values; pending bundle is lost.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → in_ready=0, out_valid=0, bs=3'b100, counters 0.
- R-type: in_inst=16'hF28A (OP F, RS=1, RT=2, RD=1, FUNCT=2), out_ready=1 → next cycle dr=1, sa=1, sb=0, fs=2, ld=1, issue_cnt=1.
- Load-use: 16'h2283 (load r2←[r1+3]) then 16'hF4A8 (RS=2) → one bubble cycle, in_ready low for exactly one cycle, stall_cnt=1, second instruction appears one cycle later.
- Backpressure: out_ready=0 for 3 cycles with a BEQ (16'h8285) held → bundle stable (bs=0, off=5), in_ready=0; released → issue_cnt increments once.
- Halt: 16'h0001 accepted → halted=1 next cycle, in_ready=0; resume pulse → halted=0, next instruction accepted.
- Flush: flush concurrent with in_valid and a held halt → out_valid=0, halted=0, input not accepted, issue_cnt unchanged.
